// File: rtl/miriscv_lsu_pkg.sv
// Shared definitions for the miriscv load/store unit: size codes, FSM states
// and size-code normalisation.
package miriscv_lsu_pkg;

    localparam logic [2:0] LDST_B  = 3'd0;
    localparam logic [2:0] LDST_H  = 3'd1;
    localparam logic [2:0] LDST_W  = 3'd2;
    localparam logic [2:0] LDST_BU = 3'd4;
    localparam logic [2:0] LDST_HU = 3'd5;

    typedef enum logic {
        IDLE,
        RESP
    } lsu_state_e;

    // Unused encodings (3, 6, 7) behave as full-word accesses.
    function automatic logic [2:0] ldst_norm(input logic [2:0] size);
        logic [2:0] res;
        case (size)
            LDST_B, LDST_H, LDST_W, LDST_BU, LDST_HU: res = size;
            default:                                  res = LDST_W;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/miriscv_lsu_extend.sv
// Load-data extraction: selects the addressed byte/halfword of a memory word
// and sign- or zero-extends it according to the access size.
module miriscv_lsu_extend
    import miriscv_lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  size,
    output logic [31:0] data_ext
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = '0;
        case (offset)
            2'd0: byte_sel = rdata[7:0];
            2'd1: byte_sel = rdata[15:8];
            2'd2: byte_sel = rdata[23:16];
            2'd3: byte_sel = rdata[31:24];
            default: byte_sel = '0;
        endcase
        half_sel = offset[1] ? rdata[31:16] : rdata[15:0];

        data_ext = '0;
        case (size)
            LDST_B:  data_ext = {{24{byte_sel[7]}}, byte_sel};
            LDST_BU: data_ext = {24'd0, byte_sel};
            LDST_H:  data_ext = {{16{half_sel[15]}}, half_sel};
            LDST_HU: data_ext = {16'd0, half_sel};
            default: data_ext = rdata;
        endcase
    end

endmodule

// File: rtl/miriscv_lsu.sv
// Load/store unit between the core and the RAM data port. Optional macro
// MIRISCV_LSU_MISALIGN_TRAP_EN rejects misaligned accesses instead of forcing them aligned.
module miriscv_lsu
    import miriscv_lsu_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              lsu_req_i,
    input  logic              lsu_we_i,
    input  logic [2:0]        lsu_size_i,
    input  logic [ADDR_W-1:0] lsu_addr_i,
    input  logic [DATA_W-1:0] lsu_data_i,
    output logic [DATA_W-1:0] lsu_data_o,
    output logic              lsu_stall_req_o,
    output logic              lsu_misalign_o,
    output logic              data_req_o,
    output logic              data_we_o,
    output logic [3:0]        data_be_o,
    output logic [ADDR_W-1:0] data_addr_o,
    output logic [DATA_W-1:0] data_wdata_o,
    input  logic [DATA_W-1:0] data_rdata_i
);

    lsu_state_e  state;
    logic [2:0]  size_q;
    logic [1:0]  offset_q;
    logic        we_q;

    logic [2:0]  size_n;
    logic [1:0]  offset_n;
    logic [3:0]  be_n;
    logic [31:0] wdata_n;
    logic [31:0] load_ext;
    logic        issue;
`ifdef MIRISCV_LSU_MISALIGN_TRAP_EN
    logic        misaligned;
`endif

    miriscv_lsu_extend u_extend (
        .rdata    (data_rdata_i),
        .offset   (offset_q),
        .size     (size_q),
        .data_ext (load_ext)
    );

    always_comb begin
        size_n   = ldst_norm(lsu_size_i);
        offset_n = lsu_addr_i[1:0];
`ifdef MIRISCV_LSU_MISALIGN_TRAP_EN
        misaligned = (((size_n == LDST_H) || (size_n == LDST_HU)) && lsu_addr_i[0]) ||
                     ((size_n == LDST_W) && (lsu_addr_i[1:0] != 2'b00));
        issue = (state == IDLE) && lsu_req_i && !rst_n_i && !misaligned;
`else
        // Misaligned accesses are silently realigned by dropping the low bits.
        case (size_n)
            LDST_W:          offset_n = 2'b00;
            LDST_H, LDST_HU: offset_n = {lsu_addr_i[1], 1'b0};
            default:         offset_n = lsu_addr_i[1:0];
        endcase
        issue = (state == IDLE) && lsu_req_i && !rst_n_i;
`endif

        case (size_n)
            LDST_B, LDST_BU: begin
                be_n    = 4'b0001 << offset_n;
                wdata_n = {4{lsu_data_i[7:0]}};
            end
            LDST_H, LDST_HU: begin
                be_n    = 4'b0011 << {offset_n[1], 1'b0};
                wdata_n = {2{lsu_data_i[15:0]}};
            end
            default: begin
                be_n    = 4'b1111;
                wdata_n = lsu_data_i;
            end
        endcase

        data_req_o      = issue;
        lsu_stall_req_o = issue;
        data_we_o       = issue && lsu_we_i;
        data_be_o       = issue ? be_n : '0;
        data_addr_o     = issue ? {lsu_addr_i[ADDR_W-1:2], 2'b00} : '0;
        data_wdata_o    = (issue && lsu_we_i) ? wdata_n : '0;
        lsu_data_o      = ((state == RESP) && !we_q && !rst_n_i) ? load_ext : '0;
`ifdef MIRISCV_LSU_MISALIGN_TRAP_EN
        lsu_misalign_o  = (state == IDLE) && lsu_req_i && !rst_n_i && misaligned;
`else
        lsu_misalign_o  = 1'b0;
`endif
    end

    always_ff @(posedge clk_i) begin
        if (rst_n_i) begin
            state    <= IDLE;
            size_q   <= '0;
            offset_q <= '0;
            we_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (issue) begin
                        state    <= RESP;
                        size_q   <= size_n;
                        offset_q <= offset_n;
                        we_q     <= lsu_we_i;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/miriscv_lsu.md
Name: miriscv_lsu

Overview:
- Load/store unit placed directly upstream of the RAM data port; converts core load/store requests into word-wide data requests.
- Drives data_req/we/be/addr/wdata toward memory.
- Stalls the core for the single cycle of memory read latency, then aligns and sign/zero-extends returned load data.
- Checks address alignment against access size.

Parameters:
- ADDR_W, 32, width of core and memory addresses.
- DATA_W, 32, data word width; only 32 is supported.

Ports:
- clk_i  in  1  core clock
- rst_n_i  in  1  synchronous reset, active-high despite the suffix (codebase port name)
- lsu_req_i  in  1  core memory request; core holds all lsu_* inputs stable while lsu_stall_req_o=1
- lsu_we_i  in  1  1=store, 0=load
- lsu_size_i  in  3  access size code (see package)
- lsu_addr_i  in  32  byte address
- lsu_data_i  in  32  store data, LSB-justified
- lsu_data_o  out  32  load result, extended
- lsu_stall_req_o  out  1  core stall request
- lsu_misalign_o  out  1  misaligned-access pulse (tied 0 without MISALIGN_TRAP_EN)
- data_req_o  out  1  memory request
- data_we_i/o: data_we_o  out  1  memory write enable
- data_be_o  out  4  byte enables
- data_addr_o  out  32  memory address, word-aligned ([1:0]=0)
- data_wdata_o  out  32  lane-replicated store data
- data_rdata_i  in  32  memory read data, valid one cycle after data_req_o

Behaviour:
- Size codes:
  - LDST_B=0, LDST_H=1, LDST_W=2, LDST_BU=4, LDST_HU=5.
  - Codes 3, 6 and 7 are treated as LDST_W.
- FSM with two states, IDLE and RESP; reset enters IDLE.
- IDLE:
  - If lsu_req_i=1 and the access is aligned (or the trap is disabled), assert data_req_o=1 and lsu_stall_req_o=1 combinationally in the same cycle, with data_we_o=lsu_we_i.
  - Register size and addr[1:0]; next state is RESP.
  - If lsu_req_i=0, all data_* outputs are 0 and stall=0.
- RESP:
  - data_req_o=0 regardless of lsu_req_i, which guarantees no double write.
  - lsu_stall_req_o=0.
  - For loads, lsu_data_o is the extraction of data_rdata_i using the registered offset and size.
  - Next state is IDLE unconditionally.
  - Total request latency is 2 cycles; a request held for one extra cycle by the core is consumed once.
- lsu_data_o is 0 in IDLE and for stores.
- Load extraction:
  - B/BU select byte addr[1:0].
  - H/HU select halfword addr[1].
  - B/H sign-extend; BU/HU zero-extend.
  - W passes the word through.
- Store byte enables:
  - B: be = 4'b0001 << addr[1:0].
  - H: be = 4'b0011 << {addr[1],1'b0}.
  - W: be = 4'b1111.
- Store wdata replication:
  - B: {4{data[7:0]}}.
  - H: {2{data[15:0]}}.
  - W: data.
- data_addr_o = {lsu_addr_i[31:2], 2'b00}.
- Misalignment definition: H/HU with addr[0]=1, or W with addr[1:0]!=0.
- Reset mid-operation (rst_n_i=1 in RESP): next cycle is IDLE with all outputs 0; no memory request is issued in the reset cycle.
- Reset values: all outputs 0, state IDLE.

Optional Feature:
- Macro: MIRISCV_LSU_MISALIGN_TRAP_EN.
- Defined:
  - A misaligned request in IDLE issues no memory request (data_req_o=0) and no stall.
  - lsu_misalign_o=1 for exactly that cycle (combinational).
  - State stays IDLE.
- Undefined:
  - lsu_misalign_o is tied 0.
  - The offending low address bits are forced: H uses addr[0]=0, W uses addr[1:0]=0.
  - The access proceeds normally.

Decomposition:
- Package miriscv_lsu_pkg holds:
  - the size-code localparams LDST_B/H/W/BU/HU;
  - the lsu_state_e enum {IDLE, RESP}.
- Sub-module miriscv_lsu_extend is purely combinational: takes rdata, offset and size, and returns the extended load result. It is reused by the test bench as the reference model.

Test Plan:
- Store word: req=1, we=1, size=W, addr=0x10, data=0xDEADBEEF -> cycle 0: data_req=1, be=1111, addr=0x10, wdata=0xDEADBEEF, stall=1; cycle 1: req=0, stall=0.
- Store byte: addr=0x13, data=0x000000A5 -> be=1000, wdata=0xA5A5A5A5, addr=0x10.
- Load byte signed then unsigned: mem[0x10]=0x80FF7F01, addr=0x11 -> B gives 0x0000007F; addr=0x12 -> B gives 0xFFFFFFFF and BU gives 0x000000FF, each in the RESP cycle.
- Load halfword: addr=0x12 -> H gives 0xFFFF80FF and HU gives 0x000080FF; W at 0x10 gives 0x80FF7F01.
- Misalign, W at 0x12:
  - with macro: data_req=0, stall=0, misalign=1 for one cycle;
  - without macro: addr=0x10, load returns 0x80FF7F01.
- Reset in RESP: rst_n_i=1 during RESP -> next cycle data_req=0, stall=0, lsu_data_o=0; a subsequent request behaves normally.
